hub_link_router: RTL and testbench

HUB_LINK_ROUTER -- requirements
Module: hub_link_router

---
 rtl/hub_link_router.sv | 150 +++++++++++++++
 tb/tb_hub_link_router.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub_link_router.sv
// rtl/hub_link_router.sv - hub crossbar between GT links and the hub controller, one round-robin output register per destination.
// Optional HUB_DROP_COUNTER_EN adds a saturating drop_count of consumed illegal messages.
module hub_link_router #(
    parameter int NUM_LINKS    = 4,
    parameter int GT_FIFO_SIZE = 64,
    parameter int FIFO_TAG_MSB = 55,
    parameter int FIFO_TAG_LSB = 48
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_LINKS*GT_FIFO_SIZE-1:0] in_data,
    input  logic [NUM_LINKS-1:0]              in_valid,
    output logic [NUM_LINKS-1:0]              in_ready,
    output logic [NUM_LINKS*GT_FIFO_SIZE-1:0] out_data,
    output logic [NUM_LINKS-1:0]              out_valid,
    input  logic [NUM_LINKS-1:0]              out_ready,
    input  logic [GT_FIFO_SIZE-1:0]           ctrl_in_data,
    input  logic                              ctrl_in_valid,
    output logic                              ctrl_in_ready,
    output logic [GT_FIFO_SIZE-1:0]           ctrl_out_data,
    output logic                              ctrl_out_valid,
    input  logic                              ctrl_out_ready,
    output logic                              router_busy
`ifdef HUB_DROP_COUNTER_EN
    ,
    output logic [15:0]                       drop_count
`endif
);
    localparam int W        = GT_FIFO_SIZE;
    localparam int NR       = NUM_LINKS + 1;
    localparam int PW       = $clog2(NR);
    localparam int TAG_W    = FIFO_TAG_MSB - FIFO_TAG_LSB + 1;
    localparam int DEST_LSB = FIFO_TAG_LSB + TAG_W;
    localparam int DEST_MSB = DEST_LSB + 7;

    logic [W-1:0]  req_data [NR];
    logic [NR-1:0] req_valid, req_legal, req_ready, drop_vec, oready;
    logic [PW-1:0] req_tgt [NR];
    logic [NR-1:0] grant [NR];
    logic [NR-1:0] load;
    logic [PW-1:0] win [NR];
    logic [W-1:0]  data_q [NR];
    logic [NR-1:0] valid_q;
    logic [PW-1:0] ptr_q [NR];
    logic [PW-1:0] ptr_d [NR];
    // Low from reset until the first edge after release, so no handshake lands in that cycle.
    logic          active_q;

    for (genvar g = 0; g < NUM_LINKS; g++) begin : g_link
        assign req_data[g]        = in_data[g*W +: W];
        assign out_data[g*W +: W] = data_q[g];
    end
    assign req_data[NUM_LINKS] = ctrl_in_data;
    assign req_valid           = {ctrl_in_valid, in_valid};
    assign oready              = {ctrl_out_ready, out_ready};

    always_comb begin
        logic [7:0] dest;
        dest = '0;
        for (int r = 0; r < NR; r++) begin
            dest         = req_data[r][DEST_MSB:DEST_LSB];
            req_legal[r] = 1'b0;
            req_tgt[r]   = '0;
            if (dest == 8'd0 && r != NUM_LINKS) begin
                req_legal[r] = 1'b1;
                req_tgt[r]   = PW'(NUM_LINKS);
            end else if (dest != 8'd0 && int'(dest) <= NUM_LINKS) begin
                req_legal[r] = 1'b1;
                req_tgt[r]   = PW'(dest - 8'd1);
            end
        end
    end

    assign drop_vec = req_valid & ~req_legal & {NR{active_q}};

    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < NR; o++) begin
            grant[o] = '0;
            load[o]  = 1'b0;
            win[o]   = '0;
            ptr_d[o] = ptr_q[o];
            if (active_q && (!valid_q[o] || oready[o])) begin
                for (int k = 0; k < NR; k++) begin
                    idx = int'(ptr_q[o]) + k;
                    if (idx >= NR) idx = idx - NR;
                    if (!load[o] && req_valid[idx] && req_legal[idx] && req_tgt[idx] == PW'(o)) begin
                        load[o]       = 1'b1;
                        win[o]        = PW'(idx);
                        grant[o][idx] = 1'b1;
                        ptr_d[o]      = (idx == NR - 1) ? '0 : PW'(idx + 1);
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = drop_vec;
        for (int o = 0; o < NR; o++) req_ready = req_ready | grant[o];
    end

    assign in_ready       = req_ready[NUM_LINKS-1:0];
    assign ctrl_in_ready  = req_ready[NUM_LINKS];
    assign out_valid      = valid_q[NUM_LINKS-1:0];
    assign ctrl_out_valid = valid_q[NUM_LINKS];
    assign ctrl_out_data  = data_q[NUM_LINKS];
    assign router_busy    = !reset && (|req_valid || |valid_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            valid_q  <= '0;
            for (int o = 0; o < NR; o++) begin
                data_q[o] <= '0;
                ptr_q[o]  <= '0;
            end
        end else begin
            active_q <= 1'b1;
            for (int o = 0; o < NR; o++) begin
                ptr_q[o] <= ptr_d[o];
                if (load[o]) begin
                    data_q[o]  <= req_data[win[o]];
                    valid_q[o] <= 1'b1;
                end else if (oready[o]) begin
                    valid_q[o] <= 1'b0;
                end
            end
        end
    end

`ifdef HUB_DROP_COUNTER_EN
    logic [15:0] drop_q, drop_d;
    logic [16:0] drop_sum;

    always_comb begin
        drop_sum = {1'b0, drop_q};
        for (int r = 0; r < NR; r++) drop_sum = drop_sum + 17'(drop_vec[r]);
        drop_d = drop_sum[16] ? 16'hffff : drop_sum[15:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_q <= '0;
        else       drop_q <= drop_d;
    end

    assign drop_count = drop_q;
`endif
endmodule

// File: tb/tb_hub_link_router.sv
// tb/tb_hub_link_router.sv - scenario tasks plus a per-output scoreboard for hub_link_router.
module tb_hub_link_router;
    localparam int N  = 4;
    localparam int W  = 64;
    localparam int NR = N + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid, in_ready;
    logic [N*W-1:0]   out_data;
    logic [N-1:0]     out_valid, out_ready;
    logic [W-1:0]     ctrl_in_data, ctrl_out_data;
    logic             ctrl_in_valid, ctrl_in_ready, ctrl_out_valid, ctrl_out_ready;
    logic             router_busy;
`ifdef HUB_DROP_COUNTER_EN
    logic [15:0]      drop_count;
`endif

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] sb_q [NR][$];

    hub_link_router dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ctrl_in_data(ctrl_in_data), .ctrl_in_valid(ctrl_in_valid), .ctrl_in_ready(ctrl_in_ready),
        .ctrl_out_data(ctrl_out_data), .ctrl_out_valid(ctrl_out_valid), .ctrl_out_ready(ctrl_out_ready),
        .router_busy(router_busy)
`ifdef HUB_DROP_COUNTER_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard: handshakes seen at the falling edge complete on the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            for (int o = 0; o < NR; o++) begin
                logic v, rd;
                logic [W-1:0] d, e;
                v  = (o == N) ? ctrl_out_valid : out_valid[o];
                rd = (o == N) ? ctrl_out_ready : out_ready[o];
                d  = (o == N) ? ctrl_out_data  : out_data[o*W +: W];
                if (v && rd) begin
                    checks++;
                    if (sb_q[o].size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected out=%0d got=%h expected=none", o, d);
                    end else begin
                        e = sb_q[o].pop_front();
                        if (d !== e) begin
                            failures++;
                            $display("FAIL sb_data out=%0d got=%h expected=%h", o, d, e);
                        end
                    end
                end
            end
            for (int r = 0; r < NR; r++) begin
                logic v, rd;
                logic [W-1:0] d;
                logic [7:0] dest;
                v    = (r == N) ? ctrl_in_valid : in_valid[r];
                rd   = (r == N) ? ctrl_in_ready : in_ready[r];
                d    = (r == N) ? ctrl_in_data  : in_data[r*W +: W];
                dest = d[63:56];
                if (v && rd) begin
                    if (dest == 8'd0 && r != N) sb_q[N].push_back(d);
                    else if (dest >= 8'd1 && dest <= 8'(N)) sb_q[dest - 8'd1].push_back(d);
                end
            end
        end
    end

    task automatic idle;
        in_valid       = '0;
        ctrl_in_valid  = 1'b0;
        out_ready      = '1;
        ctrl_out_ready = 1'b1;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (out_valid !== 4'b0 || ctrl_out_valid !== 1'b0) begin failures++;
            $display("FAIL reset_valid got=%b/%b expected=0", out_valid, ctrl_out_valid); end
        checks++; if (in_ready !== 4'b0 || ctrl_in_ready !== 1'b0) begin failures++;
            $display("FAIL reset_ready got=%b/%b expected=0", in_ready, ctrl_in_ready); end
        checks++; if (router_busy !== 1'b0) begin failures++;
            $display("FAIL reset_busy got=%b expected=0", router_busy); end
    endtask

    task automatic test_single;
        logic [W-1:0] m;
        m = {8'h03, 8'hA5, 48'h0000_1111_2222};
        @(posedge clk); #1;
        in_data[0 +: W] = m; in_valid[0] = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 4'b0001) begin failures++;
            $display("FAIL single_in_ready got=%b expected=0001", in_ready); end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 4'b0100) begin failures++;
            $display("FAIL single_out_valid got=%b expected=0100", out_valid); end
        checks++; if (out_data[2*W +: W] !== m) begin failures++;
            $display("FAIL single_out_data got=%h expected=%h", out_data[2*W +: W], m); end
        checks++; if (in_ready !== 4'b0000) begin failures++;
            $display("FAIL single_ready_pulse got=%b expected=0000", in_ready); end
    endtask

    task automatic test_round_robin;
        int order [3] = '{0, 1, 3};
        int seq [N];
        logic [N-1:0] seen, exp_r;
        for (int r = 0; r < N; r++) seq[r] = 0;
        @(posedge clk); #1;
        for (int r = 0; r < N; r++) if (r != 2) begin
            in_data[r*W +: W] = {8'h02, 8'h11, 16'(r), 32'(seq[r])};
            in_valid[r] = 1'b1;
        end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            exp_r = 4'(1 << order[i % 3]);
            seen  = in_ready;
            checks++; if (seen !== exp_r) begin failures++;
                $display("FAIL rr_grant step=%0d got=%b expected=%b", i, seen, exp_r); end
            if (i > 0) begin
                checks++; if (out_valid[1] !== 1'b1) begin failures++;
                    $display("FAIL rr_gap step=%0d got=%b expected=1", i, out_valid[1]); end
            end
            @(posedge clk); #1;
            for (int r = 0; r < N; r++) if (seen[r]) begin
                seq[r]++;
                in_data[r*W +: W] = {8'h02, 8'h11, 16'(r), 32'(seq[r])};
            end
        end
        idle();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_backpressure;
        logic [W-1:0] m1, m2;
        m1 = {8'h00, 8'h21, 48'hAAAA_0000_0001};
        m2 = {8'h00, 8'h22, 48'hAAAA_0000_0002};
        @(posedge clk); #1;
        ctrl_out_ready = 1'b0;
        in_data[2*W +: W] = m1; in_valid[2] = 1'b1;
        @(negedge clk);
        checks++; if (in_ready[2] !== 1'b1) begin failures++;
            $display("FAIL bp_first got=%b expected=1", in_ready[2]); end
        @(posedge clk); #1;
        in_data[2*W +: W] = m2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (ctrl_out_valid !== 1'b1 || ctrl_out_data !== m1 || in_ready[2] !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=%b/%h/%b expected=1/%h/0", i, ctrl_out_valid, ctrl_out_data, in_ready[2], m1);
            end
        end
        @(posedge clk); #1;
        ctrl_out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready[2] !== 1'b1) begin failures++;
            $display("FAIL bp_release got=%b expected=1", in_ready[2]); end
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        @(negedge clk);
        checks++; if (ctrl_out_valid !== 1'b1 || ctrl_out_data !== m2) begin failures++;
            $display("FAIL bp_second got=%b/%h expected=1/%h", ctrl_out_valid, ctrl_out_data, m2); end
        idle();
    endtask

    task automatic test_illegal;
        @(posedge clk); #1;
        in_data[1*W +: W] = {8'h09, 8'h33, 48'h1};
        ctrl_in_data      = {8'h00, 8'h44, 48'h2};
        in_valid[1] = 1'b1; ctrl_in_valid = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 4'b0010 || ctrl_in_ready !== 1'b1) begin failures++;
            $display("FAIL illegal_consume got=%b/%b expected=0010/1", in_ready, ctrl_in_ready); end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++; if (out_valid !== 4'b0 || ctrl_out_valid !== 1'b0) begin failures++;
            $display("FAIL illegal_forward got=%b/%b expected=0000/0", out_valid, ctrl_out_valid); end
`ifdef HUB_DROP_COUNTER_EN
        checks++; if (drop_count !== 16'd2) begin failures++;
            $display("FAIL drop_count got=%0d expected=2", drop_count); end
`endif
    endtask

    task automatic test_ctrl_in;
        logic [W-1:0] m;
        m = {8'h04, 8'h7E, 48'hCAFE_F00D_BEEF};
        @(posedge clk); #1;
        ctrl_in_data = m; ctrl_in_valid = 1'b1;
        @(negedge clk);
        checks++; if (ctrl_in_ready !== 1'b1) begin failures++;
            $display("FAIL ctrl_in_ready got=%b expected=1", ctrl_in_ready); end
        @(posedge clk); #1;
        ctrl_in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 4'b1000 || out_data[3*W +: W] !== m) begin failures++;
            $display("FAIL ctrl_in_route got=%b/%h expected=1000/%h", out_valid, out_data[3*W +: W], m); end
    endtask

    task automatic test_back_to_back;
        logic [NR-1:0] acc, vld;
        int seq = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            acc = {ctrl_in_valid & ctrl_in_ready, in_valid & in_ready};
            vld = {ctrl_in_valid, in_valid};
            @(posedge clk); #1;
            for (int r = 0; r < NR; r++) begin
                if (!vld[r] || acc[r]) begin
                    logic [W-1:0] m;
                    logic v;
                    seq++;
                    m = {8'($urandom_range(0, 5)), 8'($urandom), 16'(r), 32'(seq)};
                    v = ($urandom_range(0, 3) != 0);
                    if (r == N) begin ctrl_in_data = m; ctrl_in_valid = v; end
                    else begin in_data[r*W +: W] = m; in_valid[r] = v; end
                end
            end
            out_ready      = 4'($urandom);
            ctrl_out_ready = 1'($urandom);
        end
        idle();
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        in_data[1*W +: W] = {8'h01, 8'h55, 48'h10};
        in_valid[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        in_data[0*W +: W] = {8'h01, 8'h56, 48'h20};
        in_data[3*W +: W] = {8'h01, 8'h57, 48'h30};
        in_valid[0] = 1'b1; in_valid[3] = 1'b1;
        @(negedge clk);
        checks++; if (out_valid[0] !== 1'b1 || in_ready !== 4'b0) begin failures++;
            $display("FAIL rst_setup got=%b/%b expected=1/0000", out_valid[0], in_ready); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 4'b0 || in_ready !== 4'b0 || router_busy !== 1'b0) begin failures++;
            $display("FAIL rst_async got=%b/%b/%b expected=0000/0000/0", out_valid, in_ready, router_busy); end
        checks++; if (out_data !== '0) begin failures++;
            $display("FAIL rst_data got=%h expected=0", out_data); end
        for (int o = 0; o < NR; o++) sb_q[o].delete();
        out_ready[0] = 1'b1;
        @(negedge clk); #2 reset = 1'b0;
        #2;
        checks++; if (in_ready !== 4'b0) begin failures++;
            $display("FAIL rst_release_cycle got=%b expected=0000", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 4'b0001) begin failures++;
            $display("FAIL rst_ptr_first got=%b expected=0001", in_ready); end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 4'b1000) begin failures++;
            $display("FAIL rst_ptr_second got=%b expected=1000", in_ready); end
        @(posedge clk); #1;
        idle();
        repeat (2) @(posedge clk);
    endtask

`ifdef HUB_DROP_COUNTER_EN
    task automatic test_saturate;
        @(posedge clk); #1;
        for (int r = 0; r < N; r++) in_data[r*W +: W] = {8'hFF, 56'(r)};
        ctrl_in_data = {8'h00, 56'h5};
        in_valid = '1; ctrl_in_valid = 1'b1;
        repeat (13200) @(posedge clk);
        #1 idle();
        @(negedge clk);
        checks++; if (drop_count !== 16'hffff) begin failures++;
            $display("FAIL drop_saturate got=%h expected=ffff", drop_count); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        in_data = '0; ctrl_in_data = '0;
        idle();
        test_reset();
        @(negedge clk); reset = 1'b0;
        test_single();
        test_round_robin();
        test_backpressure();
        test_illegal();
        test_ctrl_in();
        test_back_to_back();
        test_reset_mid();
`ifdef HUB_DROP_COUNTER_EN
        test_saturate();
`endif
        idle();
        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int o = 0; o < NR; o++) begin
            checks++; if (sb_q[o].size() != 0) begin failures++;
                $display("FAIL sb_lost out=%0d got=%0d pending expected=0", o, sb_q[o].size()); end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
